// File: rtl/usr_seq_ctrl_if.sv
// Command, serial stream and usr control bundle for usr_seq_ctrl.
// slave = sequencer side, master = command source / usr side.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_out;
  logic             ser_out_valid;
  logic             ser_in;
  logic             ser_in_req;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] usr_data;
  logic             usr_msb_in;
  logic             usr_lsb_in;
  logic [WIDTH-1:0] usr_q;
  logic             usr_msb_out;
  logic             usr_lsb_out;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data,
    input  ser_in, usr_q,
    input  usr_msb_out, usr_lsb_out,
    output cmd_ready, ser_out, ser_out_valid,
    output ser_in_req, rx_data, rx_valid,
    output busy, s1, s0, usr_data,
    output usr_msb_in, usr_lsb_in
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_data,
    output ser_in, usr_q,
    output usr_msb_out, usr_lsb_out,
    input  cmd_ready, ser_out, ser_out_valid,
    input  ser_in_req, rx_data, rx_valid,
    input  busy, s1, s0, usr_data,
    input  usr_msb_in, usr_lsb_in
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving a universal shift register: load-then-serialise
// transmit and shift-then-capture receive, in either direction.
module usr_seq_ctrl #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input logic           clk,
  input logic           rst,
  usr_seq_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TX_SHIFT,
    RX_SHIFT,
    CAPTURE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             ready_q;
  logic             busy_q;
  logic             sov_q;
  logic             req_q;
  logic [1:0]       s_q;
  logic             last;
  logic             left;
  logic [1:0]       shift_s;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    last    = (cnt_q == CW'(WIDTH - 1));
    left    = mode_q[0];
    shift_s = left ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      data_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      sov_q      <= 1'b0;
      req_q      <= 1'b0;
      s_q        <= 2'b00;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io.cmd_valid) begin
            mode_q  <= io.cmd_mode;
            data_q  <= io.cmd_data;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (io.cmd_mode[1]) begin
              state_q <= RX_SHIFT;
              req_q   <= 1'b1;
              s_q     <= io.cmd_mode[0]
                         ? 2'b10 : 2'b01;
            end else begin
              state_q <= LOAD;
              s_q     <= 2'b11;
            end
          end
        end
        LOAD: begin
          state_q <= TX_SHIFT;
          cnt_q   <= '0;
          s_q     <= shift_s;
          sov_q   <= 1'b1;
        end
        TX_SHIFT: begin
          cnt_q <= cnt_d;
          if (last) begin
            state_q <= IDLE;
            s_q     <= 2'b00;
            sov_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RX_SHIFT: begin
          cnt_q <= cnt_d;
          if (last) begin
            state_q <= CAPTURE;
            s_q     <= 2'b00;
            req_q   <= 1'b0;
          end
        end
        CAPTURE: begin
          rx_data_q  <= io.usr_q;
          rx_valid_q <= 1'b1;
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          s_q     <= 2'b00;
          sov_q   <= 1'b0;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Serial taps follow the live usr ends; only the active side sees ser_in.
  assign io.ser_out = sov_q &
    (left ? io.usr_msb_out : io.usr_lsb_out);
  assign io.usr_msb_in =
    (req_q && !left) ? io.ser_in : FILL;
  assign io.usr_lsb_in =
    (req_q && left) ? io.ser_in : FILL;

  assign io.cmd_ready     = ready_q;
  assign io.ser_out_valid = sov_q;
  assign io.ser_in_req    = req_q;
  assign io.rx_data       = rx_data_q;
  assign io.rx_valid      = rx_valid_q;
  assign io.busy          = busy_q;
  assign io.s1            = s_q[1];
  assign io.s0            = s_q[0];
  assign io.usr_data      = data_q;
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl with a behavioural usr and a word-level
// reference for transmitted bit order and received word assembly.
module tb_usr_seq_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usr_seq_ctrl_if #(.WIDTH(W)) bus();

  usr_seq_ctrl #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  logic [W-1:0] usr_reg;
  always @(posedge clk) begin
    if (rst) usr_reg <= '0;
    else begin
      case ({bus.s1, bus.s0})
        2'b01: usr_reg <= {bus.usr_msb_in, usr_reg[W-1:1]};
        2'b10: usr_reg <= {usr_reg[W-2:0], bus.usr_lsb_in};
        2'b11: usr_reg <= bus.usr_data;
        default: usr_reg <= usr_reg;
      endcase
    end
  end
  assign bus.usr_q       = usr_reg;
  assign bus.usr_msb_out = usr_reg[W-1];
  assign bus.usr_lsb_out = usr_reg[0];

  int checks   = 0;
  int failures = 0;

  function automatic logic [W-1:0] rx_word(
    input logic [1:0] m, input logic [W-1:0] bits);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (m[0]) w[W-1-i] = bits[i];
      else      w[i]     = bits[i];
    end
    return w;
  endfunction

  task automatic issue(input logic [1:0] m,
                       input logic [W-1:0] d);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_data  = d;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic tx_body(input logic [1:0] m,
                         input logic [W-1:0] d);
    logic       eb;
    logic [1:0] es;
    @(negedge clk);
    checks++;
    if ({bus.s1, bus.s0} !== 2'b11 || bus.usr_data !== d ||
        bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 ||
        bus.ser_out_valid !== 1'b0 || bus.rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL tx_load s=%b%b data=%h busy=%b rdy=%b sov=%b rxv=%b exp s=11 data=%h",
               bus.s1, bus.s0, bus.usr_data, bus.busy,
               bus.cmd_ready, bus.ser_out_valid, bus.rx_valid, d);
    end
    es = m[0] ? 2'b10 : 2'b01;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      eb = m[0] ? d[W-1-i] : d[i];
      checks++;
      if (bus.ser_out_valid !== 1'b1 || bus.ser_out !== eb ||
          {bus.s1, bus.s0} !== es) begin
        failures++;
        $display("FAIL tx_bit%0d sov=%b bit=%b s=%b%b exp bit=%b s=%b",
                 i, bus.ser_out_valid, bus.ser_out,
                 bus.s1, bus.s0, eb, es);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.ser_out_valid !== 1'b0 ||
        bus.ser_out !== 1'b0 || bus.usr_q !== '0 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tx_end rdy=%b sov=%b so=%b usr_q=%h busy=%b exp 1 0 0 0 0",
               bus.cmd_ready, bus.ser_out_valid, bus.ser_out,
               bus.usr_q, bus.busy);
    end
  endtask

  task automatic rx_body(input logic [1:0] m,
                         input logic [W-1:0] bits,
                         input bit poke,
                         input bit b2b,
                         input logic [1:0] nm,
                         input logic [W-1:0] nd);
    logic [W-1:0] w;
    logic [1:0]   es;
    w  = rx_word(m, bits);
    es = m[0] ? 2'b10 : 2'b01;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ser_in_req !== 1'b1 || {bus.s1, bus.s0} !== es ||
          bus.ser_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rx_shift%0d req=%b s=%b%b sov=%b exp req=1 s=%b",
                 i, bus.ser_in_req, bus.s1, bus.s0,
                 bus.ser_out_valid, es);
      end
      bus.ser_in = bits[i];
      if (poke && i == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 2'b00;
        bus.cmd_data  = 4'hF;
      end
      if (poke && i == 2) bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    bus.ser_in = 1'($urandom);
    checks++;
    if (bus.ser_in_req !== 1'b0 || {bus.s1, bus.s0} !== 2'b00 ||
        bus.rx_valid !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rx_capture req=%b s=%b%b rxv=%b busy=%b exp 0 00 0 1",
               bus.ser_in_req, bus.s1, bus.s0,
               bus.rx_valid, bus.busy);
    end
    if (b2b) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = nm;
      bus.cmd_data  = nd;
    end
    @(negedge clk);
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== w ||
        bus.usr_q !== w || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rx_done rxv=%b rx_data=%h usr_q=%h rdy=%b exp rxv=1 word=%h",
               bus.rx_valid, bus.rx_data, bus.usr_q,
               bus.cmd_ready, w);
    end
    if (b2b) begin
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_data !== w ||
          bus.usr_q !== w) begin
        failures++;
        $display("FAIL rx_pulse rxv=%b rx_data=%h usr_q=%h exp rxv=0 word=%h",
                 bus.rx_valid, bus.rx_data, bus.usr_q, w);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 ||
        {bus.s1, bus.s0} !== 2'b00 || bus.ser_out_valid !== 1'b0 ||
        bus.ser_in_req !== 1'b0 || bus.rx_valid !== 1'b0 ||
        bus.rx_data !== '0 || bus.ser_out !== 1'b0 ||
        bus.usr_data !== '0) begin
      failures++;
      $display("FAIL reset rdy=%b busy=%b s=%b%b sov=%b req=%b rxv=%b rxd=%h so=%b ud=%h",
               bus.cmd_ready, bus.busy, bus.s1, bus.s0,
               bus.ser_out_valid, bus.ser_in_req, bus.rx_valid,
               bus.rx_data, bus.ser_out, bus.usr_data);
    end
  endtask

  task automatic test_tx_right();
    issue(2'b00, 4'b1011);
    tx_body(2'b00, 4'b1011);
  endtask

  task automatic test_tx_left();
    issue(2'b01, 4'b1011);
    tx_body(2'b01, 4'b1011);
  endtask

  task automatic test_rx_right();
    issue(2'b10, 4'h0);
    rx_body(2'b10, 4'b1001, 1'b0, 1'b0, 2'b00, 4'h0);
  endtask

  task automatic test_rx_left();
    issue(2'b11, 4'h0);
    rx_body(2'b11, 4'b0011, 1'b1, 1'b0, 2'b00, 4'h0);
  endtask

  task automatic test_reset_mid_tx();
    issue(2'b00, 4'b0110);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ser_out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold sov=%b rdy=%b exp 0 1",
               bus.ser_out_valid, bus.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.ser_out_valid !== 1'b0 ||
        {bus.s1, bus.s0} !== 2'b00 || bus.rx_data !== '0 ||
        bus.rx_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.usr_q !== '0) begin
      failures++;
      $display("FAIL rst_mid rdy=%b sov=%b s=%b%b rxd=%h rxv=%b busy=%b usr_q=%h",
               bus.cmd_ready, bus.ser_out_valid, bus.s1, bus.s0,
               bus.rx_data, bus.rx_valid, bus.busy, bus.usr_q);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b10, 4'h0);
    rx_body(2'b10, 4'b0110, 1'b0, 1'b1, 2'b01, 4'b1100);
    tx_body(2'b01, 4'b1100);
  endtask

  task automatic test_random();
    logic [1:0]   m;
    logic [W-1:0] d;
    for (int n = 0; n < 24; n++) begin
      m = 2'($urandom_range(0, 3));
      d = W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(m, d);
      if (m[1]) rx_body(m, W'($urandom), 1'($urandom),
                        1'b0, 2'b00, '0);
      else      tx_body(m, d);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'b00;
    bus.cmd_data  = '0;
    bus.ser_in    = 1'b0;
    test_reset();
    test_tx_right();
    test_tx_left();
    test_rx_right();
    test_rx_left();
    test_reset_mid_tx();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
- Sequencer that sits directly upstream of the 4-bit universal shift register (usr).
- Owns the usr mode selects and serial/parallel inputs, and observes its outputs.
- Converts one-word commands into either a parallel-load-then-serialise transmit or a serial-shift-then-capture receive, in either shift direction.
- Provides a valid/ready command port, a serial stream out and in, and a received-word output.

Parameters:
- WIDTH, 4, word/shift length; must equal the usr register width.
- FILL, 1'b0, bit driven into the vacated end during transmit shifts.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted on a clk edge where cmd_valid & cmd_ready.
- cmd_mode  input  2  00 TX right (LSB first), 01 TX left (MSB first), 10 RX right, 11 RX left.
- cmd_data  input  WIDTH  word to transmit; ignored for RX.
- ser_out  output  1  transmitted bit.
- ser_out_valid  output  1  ser_out is a valid bit this cycle.
- ser_in  input  1  received bit, sampled on each edge while ser_in_req=1.
- ser_in_req  output  1  controller consumes ser_in this cycle.
- rx_data  output  WIDTH  last received word (registered).
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- busy  output  1  state != IDLE.
- s1, s0  output  1 each  usr mode: 00 hold, 01 shift right (MSB_In enters bit3), 10 shift left (LSB_In enters bit0), 11 parallel load.
- usr_data  output  WIDTH  usr parallel input (registered copy of cmd_data).
- usr_msb_in  output  1  usr MSB serial input.
- usr_lsb_in  output  1  usr LSB serial input.
- usr_q  input  WIDTH  usr parallel output.
- usr_msb_out, usr_lsb_out  input  1 each  usr bit3 / bit0.

Behaviour:
- States: IDLE, LOAD, TX_SHIFT, RX_SHIFT, CAPTURE. Bit counter is clog2(WIDTH)+1 bits; mode_q and data_q are registered at command accept.
- Reset (rst=1 at an edge):
  - State goes to IDLE; counter, mode_q, data_q, rx_data, rx_valid are cleared to 0.
  - Outputs: s1=s0=0, cmd_ready=1, busy=0, ser_out_valid=0, ser_in_req=0, ser_out=0.
  - Reset mid-operation aborts immediately, with no rx_valid and no further ser_out_valid. The usr shares rst, so its contents also clear.
- IDLE:
  - s=00, cmd_ready=1.
  - On accept: TX modes go to LOAD; RX modes go to RX_SHIFT with counter=0.
- LOAD (1 cycle):
  - s=11, usr_data=data_q. The usr loads at the end of this cycle.
  - Next state TX_SHIFT, counter=0.
- TX_SHIFT (exactly WIDTH cycles):
  - ser_out_valid=1.
  - TX right: s=01, ser_out=usr_lsb_out, usr_msb_in=FILL.
  - TX left: s=10, ser_out=usr_msb_out, usr_lsb_in=FILL.
  - Counter increments each cycle; after cycle WIDTH-1 go to IDLE.
- RX_SHIFT (exactly WIDTH cycles):
  - ser_in_req=1.
  - RX right: s=01, usr_msb_in=ser_in. The first received bit ends in bit0.
  - RX left: s=10, usr_lsb_in=ser_in. The first received bit ends in bit WIDTH-1.
  - After cycle WIDTH-1 go to CAPTURE.
- CAPTURE (1 cycle):
  - s=00.
  - rx_data<=usr_q at the end of the cycle; rx_valid=1 the following cycle (state IDLE) for exactly one cycle.
  - The usr retains the word.
- Latency (command accepted at edge T):
  - TX bits appear in cycles T+1+1 … T+1+WIDTH.
  - cmd_ready returns at cycle T+WIDTH+2.
  - RX: ser_in sampled at edges ending cycles T+1 … T+WIDTH; rx_valid in cycle T+WIDTH+2.
- Boundary rules:
  - cmd_valid while busy is ignored (no queueing); the source holds it.
  - A new command may be accepted in the same cycle rx_valid is high.
  - Unused serial input (the side not selected) is driven to FILL.
  - ser_out is 0 when ser_out_valid=0.
  - usr_data holds data_q at all times.

Test Plan:
- Reset: assert rst 2 cycles mid-TX_SHIFT -> next cycle IDLE, cmd_ready=1, ser_out_valid=0, s1s0=00, rx_data=0.
- TX right, cmd_data=4'b1011 -> one LOAD cycle with s=11, then ser_out_valid=1 for 4 cycles with bits 1,1,0,1; usr_q ends 0000; cmd_ready back after 6 cycles.
- TX left, cmd_data=4'b1011 -> bits 1,0,1,1 with s=10; usr_q ends 0000.
- RX right, ser_in=1,0,0,1 over the 4 ser_in_req cycles -> rx_data=4'b1001 with a single rx_valid pulse; usr_q=1001 held.
- RX left, ser_in=1,1,0,0 -> rx_data=4'b1100; cmd_valid pulsed during RX_SHIFT is ignored.
- Back-to-back: RX then TX with cmd_valid held high -> TX accepted in the rx_valid cycle, and its LOAD follows with no idle gap.
